dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder serving the CPU core's LW/SW load/store port. It accepts one request at a time over a valid/ready handshake and applies a configurable number of wait states. It performs a word read or write on an internal array and returns a one-cycle response pulse with read data or an error flag. It sits between the core's memory stage (the initiator) and on-chip data storage.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of 2.
- ADDR_W, 8, word-index width, equal to log2(DEPTH).
- WAIT_CYCLES, 0, wait states inserted between accept and memory access; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  32  byte address; word index is req_addr[ADDR_W+1:2].
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned or out of range); valid only with resp_valid.

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - State is IDLE and the wait counter is 0.
  - Array contents are not cleared by reset.
- States: IDLE, WAIT, RESP.
- Accept:
  - A request is accepted at a rising edge where req_valid && req_ready. Call this edge E0.
  - we, addr and wdata are latched at E0.
  - req_valid seen while req_ready=0 is ignored; the initiator must hold it.
- req_ready is 1 only in IDLE, and 0 in WAIT and RESP.
- Error check uses the latched address:
  - misaligned: addr[1:0] != 0.
  - out of range: addr[31:ADDR_W+2] != 0. The address must not alias into the array.
- Transitions:
  - IDLE -> WAIT at E0 when WAIT_CYCLES>0. The counter loads WAIT_CYCLES-1.
  - IDLE -> RESP at E0 when WAIT_CYCLES=0.
  - WAIT decrements the counter each edge and moves to RESP on the edge where the counter is 0.
  - RESP -> IDLE unconditionally at the next edge.
- Access edge: the edge entering RESP.
  - Store with no error: the array word is written at this edge.
  - Load with no error: resp_rdata is registered from the array at this edge.
  - Error: no array access, resp_err=1, resp_rdata=0.
- Latency:
  - resp_valid is high during exactly one cycle, namely cycle W, where cycle k is the interval after edge E0+k.
  - req_ready returns high in cycle W+1.
  - Peak throughput is one request per W+2 cycles.
- resp_rdata and resp_err hold their values after resp_valid falls, until the next access edge.
- Read-after-write: a load accepted after a store's response returns the stored data.
- There is no resp_ready. The initiator must sample the response in the pulse cycle.
- Reset mid-operation:
  - Reset aborts any pending request and no response is produced.
  - If reset coincides with the access edge, reset wins and the store is dropped.

Optional Feature:
Macro DMEM_BYTE_LANES_EN.
- Defined:
  - Adds input port req_be [3:0], byte-write enables; req_be[i] covers bits 8i+7:8i.
  - Stores write only the enabled bytes.
  - A store with req_be=0 is a legal no-op with resp_err=0.
  - Loads ignore req_be and return the full word.
  - The alignment rule is unchanged.
- Not defined: the req_be port is absent and every store writes all 32 bits.

Decomposition:
- Package dmem_pkg holds:
  - state encodings S_IDLE, S_WAIT, S_RESP;
  - default DEPTH/ADDR_W constants;
  - error-cause constants ERR_NONE, ERR_MISALIGN, ERR_RANGE, used internally and in the bench.
- Sub-module dmem_array:
  - synchronous write port (with byte enables under the macro);
  - combinational read port indexed by the word index.
- dmem_responder owns the FSM, latches, error check and response registers.

Test Plan:
- W=0, reset, then SW addr 0x0 data 42, then LW addr 0x0:
  - the store gives resp_valid in cycle 0 with err=0 and rdata=0;
  - the load gives rdata=42, err=0.
- W=3, LW addr 0x4 after a prior SW 0x4 of 0x1234, accept at E0:
  - req_ready is 0 in cycles 0-3;
  - resp_valid is 1 only in cycle 3 with rdata=0x1234;
  - req_ready is 1 in cycle 4.
- Misaligned LW addr 0x6 -> resp_err=1, rdata=0; a following LW 0x4 still returns 0x1234.
- Out-of-range SW addr 0x400 data 99 -> resp_err=1; LW 0x0 still returns 42, proving no aliasing.
- W=3, SW addr 0x8 data 7 accepted, reset pulsed in cycle 1:
  - no resp_valid, req_ready=1 after reset;
  - a later LW 0x8 returns the prior contents, not 7.
- DMEM_BYTE_LANES_EN: SW 0xC data 0xFFFFFFFF with be=1111, then SW 0xC data 0x0000AB00 with be=0010 -> LW 0xC returns 0xFFFFABFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder.
//   - FSM state encodings (S_IDLE, S_WAIT, S_RESP)
//   - default geometry (DMEM_DEPTH words, DMEM_ADDR_W index bits)
//   - error-cause codes and the address check used by the responder
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH  = 256;
  localparam int unsigned DMEM_ADDR_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

  // Any address bit above the word index makes the request illegal, so that
  // large addresses never wrap onto a valid word.
  function automatic logic [1:0] err_cause(input logic [31:0] addr,
                                           input int unsigned addr_w);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if ((addr >> (addr_w + 2)) != 32'd0) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request/response bundle between the core memory stage
// (master) and the data-memory responder (slave).
//   req_valid/req_ready handshake, req_we, req_addr (byte), req_wdata,
//   req_be (only with DMEM_BYTE_LANES_EN), resp_valid pulse, resp_rdata,
//   resp_err.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]  req_be;
`endif
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

`ifdef DMEM_BYTE_LANES_EN
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
`endif
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit word storage.
//   clk      - write clock
//   we_i     - write strobe for idx_i
//   idx_i    - word index for both write and read
//   wdata_i  - write data
//   wbe_i    - byte write enables (only with DMEM_BYTE_LANES_EN)
//   rdata_o  - combinational read of word idx_i
// Contents are never reset.
module dmem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [31:0]       wdata_i,
`ifdef DMEM_BYTE_LANES_EN
  input  logic [3:0]        wbe_i,
`endif
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
`ifdef DMEM_BYTE_LANES_EN
      for (int i = 0; i < 4; i++) begin
        if (wbe_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
`else
      mem_q[idx_i] <= wdata_i;
`endif
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding LW/SW responder with WAIT_CYCLES wait
// states and a one-cycle response pulse.
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - dmem_if slave: request handshake in, response pulse out
// Optional: DMEM_BYTE_LANES_EN adds per-byte store enables (bus.req_be).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH,
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef DMEM_BYTE_LANES_EN
  logic [3:0]  be_q, be_d;
  logic [3:0]  acc_be;
`endif

  logic        accept;
  logic        access;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign bus.req_ready = (state_q == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // With no wait states the access edge is the accept edge itself, so the
  // live request fields stand in for the not-yet-latched copies.
  assign acc_we    = (state_q == S_IDLE) ? bus.req_we    : we_q;
  assign acc_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
`ifdef DMEM_BYTE_LANES_EN
  assign acc_be    = (state_q == S_IDLE) ? bus.req_be    : be_q;
`endif

  assign acc_err = (err_cause(acc_addr, ADDR_W) != ERR_NONE);
  // Reset on the access edge drops the store.
  assign mem_we  = access && acc_we && !acc_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef DMEM_BYTE_LANES_EN
    be_d    = be_q;
`endif
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef DMEM_BYTE_LANES_EN
          be_d    = bus.req_be;
`endif
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WaitLoad;
          end else begin
            state_d = S_RESP;
            access  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    resp_valid_d = access;
    rdata_d      = rdata_q;
    err_d        = err_q;
    if (access) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? 32'd0 : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
`ifdef DMEM_BYTE_LANES_EN
      be_q         <= 4'd0;
`endif
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
`ifdef DMEM_BYTE_LANES_EN
      be_q         <= be_d;
`endif
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .idx_i   (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
`ifdef DMEM_BYTE_LANES_EN
    .wbe_i   (acc_be),
`endif
    .rdata_o (mem_rdata)
  );

endmodule
